// File: rtl/sfu_pkg.sv
// sfu_pkg: shared defaults and FSM state type for the SFU output streamer.
package sfu_pkg;
    localparam int DataWidth = 512;
    localparam int FifoDepth = 32;
    localparam int CntWidth  = 6;

    typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/sfu_out_fifo.sv
// sfu_out_fifo: first-word-fall-through beat buffer; full/empty derive from the level counter.
module sfu_out_fifo #(
    parameter int DataWidth = sfu_pkg::DataWidth,
    parameter int FifoDepth = sfu_pkg::FifoDepth,
    parameter int CntWidth  = sfu_pkg::CntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntWidth-1:0]  level_o
);
    localparam int PtrWidth = $clog2(FifoDepth);

    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [PtrWidth-1:0]  wptr_q, rptr_q;
    logic [CntWidth-1:0]  level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PtrWidth'(1);
            if (pop_i) rptr_q <= rptr_q + PtrWidth'(1);
            level_q <= level_q + CntWidth'(push_i) - CntWidth'(pop_i);
        end
    end

    // Storage is not reset; the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign empty_o = level_q == '0;
    assign full_o  = level_q == CntWidth'(FifoDepth);
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];
    assign level_o = level_q;
endmodule

// File: rtl/sfu_out_streamer.sv
// sfu_out_streamer: buffers one softmax vector of SFU result beats and streams it downstream
// with last/done framing and a sticky overflow flag for dropped beats.
module sfu_out_streamer #(
    parameter int DataWidth = sfu_pkg::DataWidth,
    parameter int FifoDepth = sfu_pkg::FifoDepth,
    parameter int CntWidth  = sfu_pkg::CntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CntWidth-1:0]  beats_i,
    input  logic                 in_valid_i,
    input  logic [DataWidth-1:0] in_bits_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_bits_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [CntWidth-1:0]  level_o
);
    import sfu_pkg::*;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] beats_q, beats_d, push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d;
    logic                overflow_q, overflow_d, done_q, done_d;
    logic                accept, push, pop, full, empty, last_beat;

    sfu_out_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth), .CntWidth(CntWidth)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_bits_i),
        .data_o  (out_bits_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beats_q    <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // A full buffer still accepts a beat when the head leaves in the same cycle.
    always_comb begin
        accept     = start_i && state_q == IDLE;
        pop        = !empty && out_ready_i;
        push       = in_valid_i && state_q == ACTIVE && push_cnt_q < beats_q && (!full || pop);
        last_beat  = pop_cnt_q == beats_q - CntWidth'(1);
        state_d    = (accept && beats_i != '0) ? ACTIVE : (pop && last_beat) ? IDLE : state_q;
        beats_d    = accept ? beats_i : beats_q;
        push_cnt_d = accept ? '0 : push_cnt_q + CntWidth'(push);
        pop_cnt_d  = accept ? '0 : pop_cnt_q + CntWidth'(pop);
        overflow_d = (accept ? 1'b0 : overflow_q) | (in_valid_i && !push);
        done_d     = (pop && last_beat) || (accept && beats_i == '0);
    end

    assign out_valid_o = !empty;
    assign out_last_o  = !empty && last_beat;
    assign busy_o      = state_q == ACTIVE;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_sfu_out_streamer.sv
// tb_sfu_out_streamer: directed-vector self-checking bench for sfu_out_streamer.
module tb_sfu_out_streamer;
    localparam int DW = 512;
    localparam int CW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [CW-1:0] beats_i = '0;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_bits_i = '0;
    logic          out_ready_i = 1'b0;
    logic          out_valid_o, out_last_o, busy_o, done_o, overflow_o;
    logic [DW-1:0] out_bits_o;
    logic [CW-1:0] level_o;
    int            checks = 0;
    int            errors = 0;

    sfu_out_streamer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .beats_i     (beats_i),
        .in_valid_i  (in_valid_i),
        .in_bits_i   (in_bits_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_bits_o  (out_bits_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int v, input int k);
        return {16{v[15:0], k[15:0]}};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input int n);
        start_i = 1'b1;
        beats_i = CW'(n);
        step();
        start_i = 1'b0;
        beats_i = '0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_bits"}, out_bits_o, 0);
        chk({tag, "_last"}, out_last_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_ovf"}, overflow_o, 0);
        chk({tag, "_level"}, level_o, 0);
    endtask

    // Back-to-back pushes with a always-ready sink: each beat is visible one cycle after its push.
    task automatic run_stream(input int v, input int n);
        start(n);
        chk("strm_busy", busy_o, 1);
        out_ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_valid_i = 1'b1;
            in_bits_i  = dat(v, k);
            step();
            chk("strm_valid", out_valid_o, 1);
            chk("strm_bits", out_bits_o, dat(v, k));
            chk("strm_last", out_last_o, (k == n - 1) ? 1 : 0);
            chk("strm_level", level_o, 1);
        end
        in_valid_i = 1'b0;
        step();
        chk("strm_done", done_o, 1);
        chk("strm_busy_off", busy_o, 0);
        chk("strm_ovf", overflow_o, 0);
        chk("strm_level0", level_o, 0);
        step();
        chk("strm_done_once", done_o, 0);
        out_ready_i = 1'b0;
    endtask

    initial begin
        step();
        step();
        check_idle_zero("rst");
        rst_i = 1'b0;
        step();

        run_stream(1, 4);

        // Fill to capacity with the sink stalled; the 33rd beat has no room in the vector count.
        start(32);
        for (int k = 0; k < 33; k++) begin
            in_valid_i = 1'b1;
            in_bits_i  = dat(2, k);
            step();
        end
        in_valid_i = 1'b0;
        chk("fill_level", level_o, 32);
        chk("fill_ovf", overflow_o, 1);
        chk("fill_head", out_bits_o, dat(2, 0));
        chk("fill_last", out_last_o, 0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk("drain_valid", out_valid_o, 1);
            chk("drain_bits", out_bits_o, dat(2, k));
            chk("drain_last", out_last_o, (k == 31) ? 1 : 0);
            step();
        end
        chk("drain_done", done_o, 1);
        chk("drain_busy", busy_o, 0);
        chk("drain_ovf_sticky", overflow_o, 1);
        out_ready_i = 1'b0;
        step();

        // Full buffer with simultaneous push and pop; a start while active must be ignored.
        start(34);
        chk("full_ovf_clr", overflow_o, 0);
        for (int k = 0; k < 32; k++) begin
            in_valid_i = 1'b1;
            in_bits_i  = dat(3, k);
            start_i    = (k == 10);
            beats_i    = (k == 10) ? CW'(2) : '0;
            step();
        end
        start_i = 1'b0;
        beats_i = '0;
        chk("full_level", level_o, 32);
        in_bits_i   = dat(3, 32);
        out_ready_i = 1'b1;
        step();
        chk("pp_level", level_o, 32);
        chk("pp_ovf", overflow_o, 0);
        chk("pp_head", out_bits_o, dat(3, 1));
        in_valid_i = 1'b0;
        for (int k = 1; k < 33; k++) begin
            chk("pp_bits", out_bits_o, dat(3, k));
            step();
        end
        chk("pp_empty", level_o, 0);
        chk("pp_busy", busy_o, 1);
        in_valid_i  = 1'b1;
        in_bits_i   = dat(3, 33);
        out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        chk("pp_tail_bits", out_bits_o, dat(3, 33));
        chk("pp_tail_last", out_last_o, 1);
        out_ready_i = 1'b1;
        step();
        chk("pp_done", done_o, 1);
        chk("pp_ovf_end", overflow_o, 0);
        out_ready_i = 1'b0;
        step();

        run_stream(4, 40);

        in_valid_i = 1'b1;
        in_bits_i  = dat(5, 0);
        step();
        in_valid_i = 1'b0;
        chk("idle_ovf", overflow_o, 1);
        chk("idle_valid", out_valid_o, 0);
        chk("idle_level", level_o, 0);
        start(0);
        chk("zero_done", done_o, 1);
        chk("zero_ovf_clr", overflow_o, 0);
        chk("zero_busy", busy_o, 0);
        step();
        chk("zero_done_once", done_o, 0);

        start(8);
        for (int k = 0; k < 5; k++) begin
            in_valid_i = 1'b1;
            in_bits_i  = dat(6, k);
            step();
        end
        in_valid_i = 1'b0;
        chk("mid_level", level_o, 5);
        rst_i = 1'b1;
        step();
        check_idle_zero("midrst");
        rst_i = 1'b0;
        step();
        chk("midrst_nodone", done_o, 0);
        start(0);
        chk("post_zero_done", done_o, 1);
        step();
        chk("post_zero_once", done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sfu_out_streamer.md
SFU_OUT_STREAMER -- requirements
Module: sfu_out_streamer

Interface
REQ-001 Param: DataWidth, 512, width of one result beat (PE_NUM x 32-bit FP).
REQ-002 Param: FifoDepth, 32, buffer entries (NUM_SOFTMAX_MAX/PE_NUM); power of two.
REQ-003 Param: CntWidth, 6, beat-count width ($clog2(FifoDepth)+1).
REQ-004 Reset scheme: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state rising-edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  one-cycle pulse; arms a new softmax vector.
REQ-008 beats_i  input  CntWidth  expected result beats for the vector; sampled on start_i.
REQ-009 in_valid_i  input  1  SFU result beat strobe (push-only, no backpressure).
REQ-010 in_bits_i  input  DataWidth  SFU result beat.
REQ-011 out_ready_i  input  1  downstream ready.
REQ-012 out_valid_o  output  1  beat available.
REQ-013 out_bits_o  output  DataWidth  head beat.
REQ-014 out_last_o  output  1  head beat is final beat of vector.
REQ-015 busy_o  output  1  high while ACTIVE.
REQ-016 done_o  output  1  one-cycle pulse after final beat popped.
REQ-017 overflow_o  output  1  sticky: a beat was dropped.
REQ-018 level_o  output  CntWidth  current FIFO occupancy.

Function
REQ-019 FSM states IDLE, ACTIVE; IDLE->ACTIVE on start_i with beats_i!=0; ACTIVE->IDLE the cycle after pop of final beat.
REQ-020 start_i with beats_i==0: done_o pulses next cycle, stay IDLE, overflow_o cleared.
REQ-021 start_i in ACTIVE is ignored; beats_i not resampled.
REQ-022 start_i accepted in IDLE clears overflow_o, push counter and pop counter.
REQ-023 Push = in_valid_i & ACTIVE & (push_cnt < beats) & (!full | pop this cycle).
REQ-024 in_valid_i in IDLE, after push_cnt==beats, or with full and no pop: beat dropped, overflow_o set next cycle.
REQ-025 Pop = out_valid_o & out_ready_i; out_valid_o = !empty; out_bits_o = head entry, stable while out_valid_o & !out_ready_i.
REQ-026 Latency: beat pushed at edge N is on out_bits_o with out_valid_o from cycle N+1 (registered storage, first-word-fall-through).
REQ-027 Simultaneous push and pop: both occur; level_o unchanged; valid at full and at empty+1.
REQ-028 Read/write pointers are log2(FifoDepth) bits and wrap modulo FifoDepth; full/empty from level counter.
REQ-029 out_last_o = out_valid_o & (pop_cnt == beats-1).
REQ-030 beats may exceed FifoDepth; streaming continues as long as downstream drains.
REQ-031 done_o asserted exactly one cycle, the cycle after the final pop; busy_o deasserts same cycle.
REQ-032 FIFO is empty whenever FSM returns to IDLE.

Reset
REQ-033 On rst_i: state IDLE, pointers/level/counters 0, out_valid_o 0, out_last_o 0, busy_o 0, done_o 0, overflow_o 0, level_o 0; out_bits_o 0.
REQ-034 rst_i mid-vector discards all buffered beats; no done_o emitted.

Structure
REQ-035 Shared package sfu_pkg holds DataWidth, FifoDepth, CntWidth defaults and the state enum type.
REQ-036 One sub-module: sfu_out_fifo (storage, pointers, level, full/empty); FSM and counters in sfu_out_streamer.

Verification
REQ-037 start beats=4, 4 pushes back-to-back, out_ready_i=1 -> 4 pops at cycles N+1..N+4, out_last_o on 4th, done_o one cycle later, overflow_o=0.
REQ-038 beats=32, out_ready_i=0, 33 pushes -> level_o=32, 33rd dropped, overflow_o=1, draining yields 32 beats in order, done_o after 32nd pop.
REQ-039 Full FIFO, push+pop same cycle -> level_o stays 32, no overflow.
REQ-040 beats=40, out_ready_i=1 continuously -> 40 beats out, no overflow, out_last_o on 40th.
REQ-041 in_valid_i in IDLE -> overflow_o=1, out_valid_o stays 0; next start_i clears overflow_o.
REQ-042 rst_i asserted with level_o=5 -> all outputs 0 next cycle, no done_o; start beats=0 -> done_o pulse next cycle.
